// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: select codes, FSM states,
// default width and the round-robin winner pick. Error flag support is enabled by ALU_ARB_ERR_EN.
package alu_arb_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [2:0] SEL_SUB  = 3'd0;
  localparam logic [2:0] SEL_ADD  = 3'd1;
  localparam logic [2:0] SEL_MUL  = 3'd2;
  localparam logic [2:0] SEL_DIV  = 3'd3;
  localparam logic [2:0] SEL_LAND = 3'd4;
  localparam logic [2:0] SEL_AND  = 3'd5;
  localparam logic [2:0] SEL_RAND = 3'd6;
  localparam logic [2:0] SEL_CAT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // One-hot grant: a lone requester always wins, the pointer breaks ties.
  function automatic logic [1:0] pick_winner(input logic v0, input logic v1, input logic ptr);
    logic [1:0] g;
    g[0] = v0 & (~v1 | ~ptr);
    g[1] = v1 & (~v0 | ptr);
    return g;
  endfunction

endpackage

// File: rtl/alu_arb_core.sv
// Pure combinational shared unit: half-width operands a/b, full-width select s,
// full-width result y and an error flag (divide by zero or unknown select).
module alu_arb_core
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH/2-1:0] a,
  input  logic [WIDTH/2-1:0] b,
  input  logic [WIDTH-1:0]   s,
  output logic [WIDTH-1:0]   y,
  output logic               err
);

  localparam int HW = WIDTH / 2;

  logic [WIDTH-1:0] a_ext;
  logic [WIDTH-1:0] b_ext;
  logic             s_oor;
  logic             div_zero;
  logic [2:0]       sel;

  assign a_ext    = {{HW{1'b0}}, a};
  assign b_ext    = {{HW{1'b0}}, b};
  // Codes above 7 fall back to subtract.
  assign s_oor    = |s[WIDTH-1:3];
  assign sel      = s_oor ? SEL_SUB : s[2:0];
  assign div_zero = (b == '0);

  always_comb begin
    y = '0;
    case (sel)
      SEL_SUB:  y = a_ext - b_ext;
      SEL_ADD:  y = a_ext + b_ext;
      SEL_MUL:  y = a_ext * b_ext;
      SEL_DIV:  y = div_zero ? '1 : a_ext / b_ext;
      SEL_LAND: y = {{(WIDTH-1){1'b0}}, ((|a) && (|b))};
      SEL_AND:  y = a_ext & b_ext;
      SEL_RAND: y = {{(WIDTH-1){1'b0}}, (&a)};
      SEL_CAT:  y = {a, b};
    endcase
  end

  assign err = ((sel == SEL_DIV) && div_zero) || s_oor;

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one alu_arb_core between two valid/ready requesters;
// IDLE grants, EXEC computes, RESP holds the tagged result. Optional rsp_err port: ALU_ARB_ERR_EN.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH/2-1:0] req0_a,
  input  logic [WIDTH/2-1:0] req0_b,
  input  logic [WIDTH-1:0]   req0_s,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH/2-1:0] req1_a,
  input  logic [WIDTH/2-1:0] req1_b,
  input  logic [WIDTH-1:0]   req1_s,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_y,
`ifdef ALU_ARB_ERR_EN
  output logic               rsp_id,
  output logic               rsp_err
`else
  output logic               rsp_id
`endif
);

  state_e             state_q;
  logic               ptr_q;
  logic [WIDTH/2-1:0] a_q, a_d;
  logic [WIDTH/2-1:0] b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               id_q, id_d;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [1:0]         grant;
  logic [WIDTH-1:0]   core_y;
`ifdef ALU_ARB_ERR_EN
  logic               core_err;
  logic               err_q;
`else
  logic               core_err_unused;
`endif

  // Grants exist only in IDLE; reset masks them so no handshake is seen on a reset edge.
  always_comb begin
    grant = 2'b00;
    if ((state_q == IDLE) && !rst) begin
      grant = pick_winner(req0_valid, req1_valid, ptr_q);
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign a_d  = grant[1] ? req1_a : req0_a;
  assign b_d  = grant[1] ? req1_b : req0_b;
  assign s_d  = grant[1] ? req1_s : req0_s;
  assign id_d = grant[1];
  assign y_d  = core_y;

  alu_arb_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (a_q),
    .b  (b_q),
    .s  (s_q),
    .y  (core_y),
`ifdef ALU_ARB_ERR_EN
    .err(core_err)
`else
    .err(core_err_unused)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      y_q         <= '0;
`ifdef ALU_ARB_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            id_q    <= id_d;
            // Pointer moves to the requester that did not win.
            ptr_q   <= ~id_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          y_q         <= y_d;
`ifdef ALU_ARB_ERR_EN
          err_q       <= core_err;
`endif
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = y_q;
  assign rsp_id    = id_q;
`ifdef ALU_ARB_ERR_EN
  assign rsp_err   = err_q;
`endif

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin arbiter and sequencer that shares one logical/arithmetic unit between two requesters. Each requester presents a pair of operands plus a select code through a valid/ready handshake. The block grants one requester, registers the operands, runs the shared unit for one cycle and holds the tagged result until the consumer accepts it. It sits between the two command sources and the single result sink, so neither requester drives the unit directly.

## Interface
- WIDTH, 8: result width; each operand is WIDTH/2 bits. Must be even and ≥4.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a command
- req0_ready  out  1  requester 0 command accepted this cycle when valid&ready
- req0_a, req0_b  in  WIDTH/2  requester 0 operands
- req0_s  in  WIDTH  requester 0 select code
- req1_valid, req1_ready, req1_a, req1_b, req1_s: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_y  out  WIDTH  result
- rsp_id  out  1  index of the requester that owns rsp_y
- rsp_err  out  1  error flag; present only with ALU_ARB_ERR_EN

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - reqN_ready is combinational and asserted only for the winner.
  - Winner: the sole valid requester, or the requester named by the priority pointer when both are valid.
  - On handshake: capture a, b, s and id into registers, flip the pointer to the other requester, go to EXEC.
- EXEC: evaluate the shared unit on the captured operands, register the result into rsp_y (and rsp_err), go to RESP.
- RESP: rsp_valid=1; rsp_y, rsp_id and rsp_err hold stable. On rsp_ready go to IDLE; otherwise stay.
- Both reqN_ready are 0 in EXEC and RESP. Request inputs are ignored outside IDLE.
- Select decode (operands zero-extended to WIDTH, results truncated to WIDTH):
  - 0: a−b, modulo 2^WIDTH
  - 1: a+b
  - 2: a*b
  - 3: a/b, integer quotient
  - 4: a&&b, 1-bit
  - 5: a&b, bitwise
  - 6: &a, 1-bit reduction
  - 7: {a,b}
  - any s>7: treated as 0 (subtract)
- Divide by zero: rsp_y = all ones.
- Priority pointer is not modified when there is no grant.

## Timing
- Reset values: req0_ready=0, req1_ready=0, rsp_valid=0, rsp_y=0, rsp_id=0, rsp_err=0, pointer=requester 0, state IDLE.
- Latency: request handshake in cycle N gives rsp_valid=1 in cycle N+2.
- Back-to-back: a response accepted in cycle M allows the next request handshake in M+1 at the earliest. Peak throughput is one operation per 3 cycles.
- Both requesters valid in the same IDLE cycle: only the pointer's requester is granted. The loser keeps its valid asserted and is granted in the next IDLE.
- rsp_ready asserted outside RESP is ignored.
- rst asserted in any state: the in-flight operation is discarded without a response, and all registers return to their reset values on that edge.
- Requester changes its inputs while not granted: no effect.

## Configuration
- ALU_ARB_ERR_EN defined:
  - rsp_err port exists.
  - rsp_err is set for s=3 with b=0, or for any s>7.
  - Results are unchanged: all ones for divide by zero, subtract for s>7.
- Undefined: no rsp_err port and no error logic. Data behaviour is identical.

## Structure
- Shared package alu_arb_pkg holds:
  - select-code constants SEL_SUB=0 … SEL_CAT=7
  - FSM state typedef (IDLE/EXEC/RESP)
  - default WIDTH constant
- Sub-module alu_arb_core is the pure combinational unit: a, b, s in; y and err out. It is instantiated once inside the arbiter and is reusable on its own.

## Test plan
- Single op, WIDTH=8: req0 a=4'hA b=4'h3 s=1 → rsp_y=8'h0D, rsp_id=0, rsp_valid exactly 2 cycles after handshake.
- Arithmetic sweep on req1 with a=4'hA b=4'h3, s=0..7 → 8'h07, 0D, 1E, 03, 01, 02, 00, A3. Also a=3 b=5 s=0 → 8'hFE; a=F b=F s=2 → 8'hE1; a=F s=6 → 8'h01.
- Contention: both valid from reset → req0 granted first, then req1, then req0, alternating. Each rsp_id matches its grant order.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_y/rsp_id stable, both reqN_ready=0. Release → IDLE next cycle.
- Divide by zero and s=9: s=3 b=0 → 8'hFF; s=9 a=5 b=2 → 8'h03. With ALU_ARB_ERR_EN, rsp_err=1 in both cases.
- Reset mid-op: assert rst in EXEC → no rsp_valid afterwards, pointer back to req0, next contention grants req0.
